fifo_n2w: RTL

Narrow-to-wide FIFO that accepts 8-bit bytes on its write side and delivers 16-bit words on its read side. Each accepted write advances the write pointer by one byte; each accepted read advances the read pointer by two bytes. Bytes are presented as a first-word-fall-through 16-bit word. It sits between a byte-oriented producer and a 16-bit consumer, mirroring the existing 16-to-8 FIFO path in the opposite direction.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_n2w_ctrl.sv | 72 +++++++
 rtl/fifo_n2w.sv | 54 +++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared widths and the occupancy-update helper for the narrow-to-wide FIFO.
package fifo_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned RATIO  = WORD_W / BYTE_W;

  // One byte in per accepted write, RATIO bytes out per accepted read.
  function automatic int unsigned next_count(int unsigned cnt, logic wr_acc, logic rd_acc);
    int unsigned n;
    n = cnt;
    if (wr_acc) n = n + 1;
    if (rd_acc) n = n - RATIO;
    return n;
  endfunction

endpackage

// File: rtl/fifo_n2w_ctrl.sv
// Pointer, occupancy, flag and error-pulse control for the byte-in/word-out FIFO.
module fifo_n2w_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(2**ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0]   WORD_C  = (ADDR_WIDTH+1)'(RATIO);
  localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(RATIO);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_wr_err;
  logic                  r_rd_err;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [ADDR_WIDTH:0]   w_cnt_next;

  // Accept decisions use only the registered flags, so a read never frees room
  // for a same-cycle write.
  assign w_wr_acc   = wr & ~r_full;
  assign w_rd_acc   = rd & ~r_empty;
  assign w_cnt_next = (ADDR_WIDTH+1)'(next_count(32'(r_count), w_wr_acc, w_rd_acc));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_wr_err <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + STEP_C;
      r_count  <= w_cnt_next;
      r_full   <= (w_cnt_next == DEPTH_C);
      r_empty  <= (w_cnt_next < WORD_C);
      r_wr_err <= wr & r_full;
      r_rd_err <= rd & r_empty;
    end
  end

  assign w_en       = w_wr_acc;
  assign w_addr     = r_wr_ptr;
  assign r_addr     = r_rd_ptr;
  assign full       = r_full;
  assign empty      = r_empty;
  assign byte_count = r_count;
  assign wr_err     = r_wr_err;
  assign rd_err     = r_rd_err;

endmodule

// File: rtl/fifo_n2w.sv
// Narrow-to-wide FIFO: 8-bit writes, 16-bit first-word-fall-through reads, little-endian.
module fifo_n2w
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [BYTE_W-1:0]     w_data,
  input  logic                  rd,
  output logic [WORD_W-1:0]     r_data,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic [BYTE_W-1:0]     r_mem [DEPTH];
  logic                  w_en;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic [ADDR_WIDTH-1:0] w_raddr_hi;

  fifo_n2w_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr         (wr),
    .rd         (rd),
    .w_en       (w_en),
    .w_addr     (w_waddr),
    .r_addr     (w_raddr),
    .full       (full),
    .empty      (empty),
    .byte_count (byte_count),
    .wr_err     (wr_err),
    .rd_err     (rd_err)
  );

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_en) r_mem[w_waddr] <= w_data;
  end

  // rd_ptr stays even and DEPTH is even, so the upper tap wraps cleanly.
  assign w_raddr_hi = w_raddr + ADDR_WIDTH'(1);
  assign r_data     = {r_mem[w_raddr_hi], r_mem[w_raddr]};

endmodule
